// File: rtl/zet_front_prefetch_wb.sv
// zet_front_prefetch_wb: instruction prefetch Wishbone bus master.
// Issues BURST-beat incrementing reads of 16-bit code words starting at the
// linear fetch address, and pushes each acked word into the prefetch FIFO
// byte-swapped so that the even-address byte comes out first.
// A flush discards the current stream and restarts fetching at a new address.
//
// Ports:
//   clk_i, rst_i        clock (rising edge) and asynchronous active-low reset
//   flush_i             discard the stream and restart at flush_addr_i
//   flush_addr_i        byte address of the new stream
//   fifo_afull_i        FIFO cannot take a full burst; no new burst may start
//   fifo_stb_o          push fifo_dat_o into the FIFO this cycle
//   fifo_dat_o          byte-swapped wb_dat_i
//   odd_o               stream starts at an odd byte (first byte is dropped)
//   wb_*                Wishbone B4 master, read-only, linear incrementing bursts
module zet_front_prefetch_wb #(
  parameter int BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [19:0] flush_addr_i,
  input  logic        fifo_afull_i,
  output logic        fifo_stb_o,
  output logic [15:0] fifo_dat_o,
  output logic        odd_o,
  output logic [18:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [18:0]   adr, adr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    cti, cti_nxt;
  logic          cyc, cyc_nxt;
  logic          odd, odd_nxt;
  logic          push;

  // A beat is only accepted while the burst is live and not being flushed;
  // an ack coinciding with a flush belongs to the discarded stream.
  assign push       = wb_ack_i & (state == S_BURST) & ~flush_i;
  assign fifo_stb_o = push;
  assign fifo_dat_o = {wb_dat_i[7:0], wb_dat_i[15:8]};

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    cnt_nxt   = cnt;
    cti_nxt   = cti;
    cyc_nxt   = cyc;
    odd_nxt   = odd;

    case (state)
      S_IDLE: begin
        if (flush_i) begin
          adr_nxt = flush_addr_i[19:1];
          odd_nxt = flush_addr_i[0];
        end else if (!fifo_afull_i) begin
          // FIFO has room for a whole burst, so afull is not looked at again
          // until the burst is over.
          state_nxt = S_BURST;
          cyc_nxt   = 1'b1;
          cnt_nxt   = '0;
          cti_nxt   = (LAST == '0) ? CTI_END : CTI_INCR;
        end
      end

      S_BURST: begin
        if (flush_i) begin
          // Abort with classic termination: drop cyc/stb next cycle.
          state_nxt = S_FLUSH;
          adr_nxt   = flush_addr_i[19:1];
          odd_nxt   = flush_addr_i[0];
          cyc_nxt   = 1'b0;
          cti_nxt   = CTI_CLASSIC;
          cnt_nxt   = '0;
        end else if (wb_ack_i) begin
          adr_nxt = adr + 19'd1;
          odd_nxt = 1'b0;
          if (cnt == LAST) begin
            // Returning to IDLE guarantees at least one cycle with cyc low.
            state_nxt = S_IDLE;
            cyc_nxt   = 1'b0;
            cti_nxt   = CTI_CLASSIC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
            // cti is registered so "end of burst" is presented together with
            // the strobe of the final beat.
            cti_nxt = (cnt_inc == LAST) ? CTI_END : CTI_INCR;
          end
        end
      end

      S_FLUSH: begin
        if (flush_i) begin
          adr_nxt = flush_addr_i[19:1];
          odd_nxt = flush_addr_i[0];
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cyc_nxt   = 1'b0;
        cti_nxt   = CTI_CLASSIC;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      adr   <= '0;
      cnt   <= '0;
      cti   <= CTI_CLASSIC;
      cyc   <= 1'b0;
      odd   <= 1'b0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      cnt   <= cnt_nxt;
      cti   <= cti_nxt;
      cyc   <= cyc_nxt;
      odd   <= odd_nxt;
    end
  end

  assign wb_adr_o = adr;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_cti_o = cti;
  assign wb_bte_o = 2'b00;
  assign wb_sel_o = 2'b11;
  assign wb_we_o  = 1'b0;
  assign odd_o    = odd;

endmodule

// File: tb/tb_zet_front_prefetch_wb.sv
// Bench for zet_front_prefetch_wb: directed scenarios followed by random
// flush/afull/ack-wait-state traffic, every cycle compared against a
// transaction-level model of the fetch stream.
module tb_zet_front_prefetch_wb;
  localparam int BURST = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [19:0] flush_addr_i = '0;
  logic        fifo_afull_i = 1'b0;
  logic        fifo_stb_o;
  logic [15:0] fifo_dat_o;
  logic        odd_o;
  logic [18:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  zet_front_prefetch_wb #(.BURST(BURST)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .fifo_afull_i(fifo_afull_i), .fifo_stb_o(fifo_stb_o), .fifo_dat_o(fifo_dat_o),
    .odd_o(odd_o), .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream model: is a burst on the bus, which beat of it, which word is
  // fetched next, whether the odd flag is pending, and whether we are in the
  // dead cycle after an aborted burst.
  bit          m_busy, m_cool, m_odd;
  int          m_beat;
  int unsigned m_adr;
  int          pushes;

  function automatic logic [15:0] swap16(input logic [15:0] d);
    return 16'(((d & 16'h00ff) << 8) | (d >> 8));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cool = 0; m_odd = 0; m_beat = 0; m_adr = 0; pushes = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit fl, input logic [19:0] fa, input bit af,
                      input bit ak, input logic [15:0] d);
    bit exp_push;
    flush_i = fl; flush_addr_i = fa; fifo_afull_i = af; wb_ack_i = ak; wb_dat_i = d;
    @(negedge clk_i);
    check("cyc", wb_cyc_o, m_busy);
    check("stb", wb_stb_o, m_busy);
    check("adr", wb_adr_o, m_adr);
    check("cti", wb_cti_o, m_busy ? ((m_beat == BURST - 1) ? 3'b111 : 3'b010) : 3'b000);
    check("odd", odd_o, m_odd);
    check("const", {wb_bte_o, wb_sel_o, wb_we_o}, 5'b00110);
    exp_push = ak && m_busy && !fl;
    check("push", fifo_stb_o, exp_push);
    if (exp_push) check("dat", fifo_dat_o, swap16(d));
    if (fifo_stb_o) pushes++;
    @(posedge clk_i);
    if (fl) begin
      m_adr = fa >> 1;
      m_odd = fa[0];
      if (m_busy) begin m_busy = 0; m_cool = 1; end
    end else if (m_busy) begin
      if (ak) begin
        m_odd = 0;
        m_adr = (m_adr + 1) % (1 << 19);
        m_beat++;
        if (m_beat == BURST) begin
          check("burst_pushes", pushes, BURST);
          m_busy = 0;
        end
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (!af) begin
      m_busy = 1; m_beat = 0; pushes = 0;
    end
    #1;
  endtask

  initial begin
    int wait_cnt;
    bit ak, fl, af;

    // Reset values while held in reset.
    #12;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_cti", wb_cti_o, 0);
    check("rst_odd", odd_o, 0);
    check("rst_push", fifo_stb_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Fetch starts at word 0 after reset release.
    step(0, 0, 0, 0, 0);
    check("start_cyc", wb_cyc_o, 1);
    check("start_adr", wb_adr_o, 0);
    repeat (BURST) step(0, 0, 0, 1, 16'h1234);

    // Flush to 0x00100 with zero-wait acks.
    step(1, 20'h00100, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < BURST; i++) begin
      check("burst_adr", wb_adr_o, 19'h80 + i);
      check("burst_cti", wb_cti_o, (i == BURST - 1) ? 3'b111 : 3'b010);
      wb_dat_i = 16'hBBAA; wb_ack_i = 1'b1; #1;
      check("swap", fifo_dat_o, 16'hAABB);
      step(0, 0, 0, 1, 16'hBBAA);
    end
    check("gap_cyc", wb_cyc_o, 0);
    step(0, 0, 0, 0, 0);
    check("next_cyc", wb_cyc_o, 1);
    check("next_adr", wb_adr_o, 19'h84);

    // afull rising mid-burst must not cut the burst short, then holds off.
    repeat (BURST) step(0, 0, 1, 1, 16'h5A5A);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0);
      check("afull_hold", wb_cyc_o, 0);
    end
    step(0, 0, 0, 0, 0);
    check("afull_release", wb_cyc_o, 1);
    check("afull_adr", wb_adr_o, 19'h88);

    // Flush to 0x12345 together with the ack of beat 2.
    step(0, 0, 0, 1, 16'h1111);
    step(0, 0, 0, 1, 16'h2222);
    step(1, 20'h12345, 0, 1, 16'h3333);
    check("abort_cyc", wb_cyc_o, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("odd_adr", wb_adr_o, 19'h091A2);
    check("odd_set", odd_o, 1);
    step(0, 0, 0, 1, 16'hC0DE);
    check("odd_clr", odd_o, 0);
    repeat (BURST - 1) step(0, 0, 0, 1, 16'hC0DE);

    // Address wrap at the top of the 1 MiB space.
    step(1, 20'hFFFF8, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_first", wb_adr_o, 19'h7FFFC);
    repeat (BURST) step(0, 0, 0, 1, 16'hFEED);
    check("wrap_adr", wb_adr_o, 19'h00000);
    step(0, 0, 0, 0, 0);
    check("wrap_cyc", wb_cyc_o, 1);

    // Back-to-back flushes: the last address wins.
    step(1, 20'h0AAAA, 0, 0, 0);
    step(1, 20'h05554, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reflush_adr", wb_adr_o, 19'h02AAA);
    repeat (BURST) step(0, 0, 0, 1, 16'h0F0F);

    // Random traffic: wait states 0-3, stray acks, random flush and afull.
    wait_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      if (wb_cyc_o) begin
        if (wait_cnt == 0) begin ak = 1; wait_cnt = $urandom_range(0, 3); end
        else begin ak = 0; wait_cnt--; end
      end else begin
        ak = ($urandom_range(0, 7) == 0);
      end
      fl = ($urandom_range(0, 24) == 0);
      af = ($urandom_range(0, 3) == 0);
      step(fl, 20'($urandom), af, ak, 16'($urandom));
    end

    // Asynchronous reset in the middle of a burst with odd_o set.
    step(1, 20'h00101, 0, 0, 0);
    for (int i = 0; i < 5 && !wb_cyc_o; i++) step(0, 0, 0, 0, 0);
    check("pre_rst_cyc", wb_cyc_o, 1);
    check("pre_rst_odd", odd_o, 1);
    #2;
    wb_ack_i = 1'b1;
    rst_i = 1'b0;
    #1;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_stb", wb_stb_o, 0);
    check("arst_push", fifo_stb_o, 0);
    check("arst_adr", wb_adr_o, 0);
    check("arst_odd", odd_o, 0);
    wb_ack_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    step(0, 0, 0, 0, 0);
    repeat (BURST + 2) step(0, 0, 0, 1, 16'h7788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
